// File: rtl/addsub_multiword_sequencer_if.sv
// Upstream, adder-side and downstream signals of the multiword add/sub sequencer.
// out_zero exists only when ADDSUB_SEQ_ZERO_FLAG_EN is defined.
interface addsub_multiword_sequencer_if #(
   parameter int WORD_WIDTH = 0
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_first;
   logic                  in_last;
   logic                  in_add_sub;
   logic                  in_cin;
   logic [WORD_WIDTH-1:0] in_dataa;
   logic [WORD_WIDTH-1:0] in_datab;

   logic                  alu_add_sub;
   logic                  alu_cin;
   logic [WORD_WIDTH-1:0] alu_dataa;
   logic [WORD_WIDTH-1:0] alu_datab;
   logic                  alu_cout;
   logic [WORD_WIDTH-1:0] alu_result;

   logic                  out_valid;
   logic                  out_ready;
   logic [WORD_WIDTH-1:0] out_result;
   logic                  out_last;
   logic                  out_cout;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   logic                  out_zero;
`endif

   modport slave (
      input  in_valid, in_first, in_last, in_add_sub, in_cin, in_dataa, in_datab,
      output in_ready,
      output alu_add_sub, alu_cin, alu_dataa, alu_datab,
      input  alu_cout, alu_result,
      output out_valid, out_result, out_last, out_cout,
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      output out_zero,
`endif
      input  out_ready
   );

   modport master (
      output in_valid, in_first, in_last, in_add_sub, in_cin, in_dataa, in_datab,
      input  in_ready,
      input  alu_add_sub, alu_cin, alu_dataa, alu_datab,
      output alu_cout, alu_result,
      input  out_valid, out_result, out_last, out_cout,
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      input  out_zero,
`endif
      output out_ready
   );
endinterface

// File: rtl/addsub_multiword_sequencer.sv
// Feeds multiword add/sub chains one word at a time through an external pipelined
// adder, chaining carries. Optional all-zero chain flag: ADDSUB_SEQ_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | no word in flight, ready for input
// WAIT  | word issued to adder, counting down the pipeline latency
// HOLD  | result presented, waiting for downstream to take it
module addsub_multiword_sequencer #(
   parameter int WORD_WIDTH = 0,
   parameter int LATENCY    = 2
) (
   input logic                         clock,
   input logic                         reset,
   addsub_multiword_sequencer_if.slave bus
);
   localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t                state, state_next;
   logic [CW-1:0]         cnt;
   logic                  take, capture, in_ready;
   logic                  chain_start;
   logic                  alu_add_sub, alu_cin;
   logic [WORD_WIDTH-1:0] alu_dataa, alu_datab;
   logic                  word_last, carry, chain_open;
   logic [WORD_WIDTH-1:0] out_result;
   logic                  out_last, out_cout;

   // in_first, or a continuation with nothing open, both restart from in_cin
   assign chain_start = bus.in_first || !chain_open;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      take       = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               take       = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            in_ready = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  take       = 1'b1;
                  state_next = WAIT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt         <= '0;
         alu_add_sub <= 1'b0;
         alu_cin     <= 1'b0;
         alu_dataa   <= '0;
         alu_datab   <= '0;
         word_last   <= 1'b0;
         carry       <= 1'b0;
         chain_open  <= 1'b0;
         out_result  <= '0;
         out_last    <= 1'b0;
         out_cout    <= 1'b0;
      end else begin
         if (take) begin
            alu_add_sub <= bus.in_add_sub;
            alu_dataa   <= bus.in_dataa;
            alu_datab   <= bus.in_datab;
            alu_cin     <= chain_start ? bus.in_cin : carry;
            word_last   <= bus.in_last;
            cnt         <= CW'(LATENCY);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (capture) begin
            out_result <= bus.alu_result;
            out_last   <= word_last;
            out_cout   <= word_last ? bus.alu_cout : 1'b0;
            carry      <= bus.alu_cout;
            chain_open <= !word_last;
         end
      end
   end

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   logic zero_acc, zero_next, out_zero;

   assign zero_next = zero_acc && (bus.alu_result == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         zero_acc <= 1'b0;
         out_zero <= 1'b0;
      end else begin
         if (take && chain_start) zero_acc <= 1'b1;
         if (capture) begin
            zero_acc <= zero_next;
            out_zero <= word_last ? zero_next : 1'b0;
         end
      end
   end

   assign bus.out_zero = out_zero;
`endif

   assign bus.in_ready    = in_ready;
   assign bus.alu_add_sub = alu_add_sub;
   assign bus.alu_cin     = alu_cin;
   assign bus.alu_dataa   = alu_dataa;
   assign bus.alu_datab   = alu_datab;
   assign bus.out_valid   = (state == HOLD);
   assign bus.out_result  = out_result;
   assign bus.out_last    = out_last;
   assign bus.out_cout    = out_cout;
endmodule

// File: tb/tb_addsub_multiword_sequencer.sv
// Bench for addsub_multiword_sequencer: 8-bit words, 2-stage adder model attached.
// out_zero is checked when ADDSUB_SEQ_ZERO_FLAG_EN is defined.
module tb_addsub_multiword_sequencer;
   localparam int W   = 8;
   localparam int LAT = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   addsub_multiword_sequencer_if #(.WORD_WIDTH(W)) bus ();

   addsub_multiword_sequencer #(.WORD_WIDTH(W), .LATENCY(LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // two-stage adder: in_add_sub=1 adds, 0 subtracts as a + ~b + cin
   logic [8:0] s1, s2;
   always @(posedge clock) begin
      s1 <= {1'b0, bus.alu_dataa}
          + {1'b0, (bus.alu_add_sub ? bus.alu_datab : ~bus.alu_datab)}
          + {8'd0, bus.alu_cin};
      s2 <= s1;
   end
   assign bus.alu_result = s2[7:0];
   assign bus.alu_cout   = s2[8];

   // reference chain state
   bit m_open  = 1'b0;
   bit m_carry = 1'b0;
   bit m_zac   = 1'b0;

   function automatic void model_word(input bit first, last, as, cin,
                                      input logic [7:0] a, b,
                                      output logic [7:0] r, output bit co,
                                      output bit acin, output bit z);
      bit         start;
      logic [7:0] bs;
      logic [8:0] s;
      start = first || !m_open;
      acin  = start ? cin : m_carry;
      bs    = as ? b : ~b;
      s     = {1'b0, a} + {1'b0, bs} + {8'd0, acin};
      r     = s[7:0];
      m_carry = s[8];
      m_open  = !last;
      co      = last ? s[8] : 1'b0;
      m_zac   = (start ? 1'b1 : m_zac) && (r == 8'h00);
      z       = last ? m_zac : 1'b0;
   endfunction

   task automatic run_word(input bit first, last, as, cin,
                           input logic [7:0] a, b, input int stall);
      logic [7:0] er;
      bit         eco, ecin, ez;
      int         n;
      model_word(first, last, as, cin, a, b, er, eco, ecin, ez);
      bus.in_valid   = 1'b1;
      bus.in_first   = first;
      bus.in_last    = last;
      bus.in_add_sub = as;
      bus.in_cin     = cin;
      bus.in_dataa   = a;
      bus.in_datab   = b;
      bus.out_ready  = (stall == 0);
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      n_checks++;
      if (n >= 20) begin n_fail++; $display("FAIL in_ready_timeout: waited %0d cycles, required ready", n); end
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      n_checks++;
      if (n !== LAT + 1) begin n_fail++; $display("FAIL latency: got %0d edges, required %0d", n, LAT + 1); end
      n_checks++;
      if (bus.out_result !== er) begin n_fail++; $display("FAIL out_result: got %h, required %h", bus.out_result, er); end
      n_checks++;
      if (bus.out_last !== last) begin n_fail++; $display("FAIL out_last: got %b, required %b", bus.out_last, last); end
      n_checks++;
      if (bus.out_cout !== eco) begin n_fail++; $display("FAIL out_cout: got %b, required %b", bus.out_cout, eco); end
      n_checks++;
      if (bus.alu_cin !== ecin) begin n_fail++; $display("FAIL alu_cin: got %b, required %b", bus.alu_cin, ecin); end
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      n_checks++;
      if (bus.out_zero !== ez) begin n_fail++; $display("FAIL out_zero: got %b, required %b", bus.out_zero, ez); end
`endif
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_result !== er || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b result=%h ready=%b, required 1/%h/0",
                     bus.out_valid, bus.out_result, bus.in_ready, er);
         end
      end
      bus.out_ready = 1'b1;
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %b, required 0", bus.out_valid); end
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
      bus.in_add_sub = 1'b0; bus.in_cin = 1'b0; bus.in_dataa = '0; bus.in_datab = '0;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_result !== 8'h00 || bus.out_last !== 1'b0 || bus.out_cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: valid=%b result=%h last=%b cout=%b, required all 0",
                  bus.out_valid, bus.out_result, bus.out_last, bus.out_cout);
      end
      n_checks++;
      if (bus.alu_dataa !== 8'h00 || bus.alu_datab !== 8'h00 || bus.alu_cin !== 1'b0 || bus.alu_add_sub !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_alu: a=%h b=%h cin=%b as=%b, required all 0",
                  bus.alu_dataa, bus.alu_datab, bus.alu_cin, bus.alu_add_sub);
      end
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.in_ready); end
   endtask

   task automatic test_directed;
      run_word(1'b1, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h01, 0);
      run_word(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h01, 0);
      run_word(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 0);
      run_word(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h01, 0);
      run_word(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0);
      run_word(1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 8'h03, 0);
      run_word(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 0);
   endtask

   task automatic test_zero_flag;
      run_word(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h01, 0);
      run_word(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 0);
      run_word(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0);
      run_word(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 0);
   endtask

   task automatic test_back_to_back;
      logic [7:0] ra, rb;
      bit         ca, cb, ia, ib, za, zb;
      int         n;
      model_word(1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h20, ra, ca, ia, za);
      model_word(1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h44, rb, cb, ib, zb);
      bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b1; bus.in_add_sub = 1'b1;
      bus.in_cin = 1'b0; bus.in_dataa = 8'h10; bus.in_datab = 8'h20;
      bus.out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus.in_dataa = 8'h33; bus.in_datab = 8'h44;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_result !== ra || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b result=%h ready=%b, required 1/%h/0",
                     bus.out_valid, bus.out_result, bus.in_ready, ra);
         end
         @(negedge clock);
      end
      bus.out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.alu_dataa !== 8'h33 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept: valid=%b alu_dataa=%h ready=%b, required 0/33/0",
                  bus.out_valid, bus.alu_dataa, bus.in_ready);
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      n_checks++;
      if (n !== LAT + 1) begin n_fail++; $display("FAIL bp_latency: got %0d edges, required %0d", n, LAT + 1); end
      n_checks++;
      if (bus.out_result !== rb || bus.out_cout !== cb) begin
         n_fail++;
         $display("FAIL bp_result: got %h/%b, required %h/%b", bus.out_result, bus.out_cout, rb, cb);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_midop;
      bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b0; bus.in_add_sub = 1'b1;
      bus.in_cin = 1'b1; bus.in_dataa = 8'hAA; bus.in_datab = 8'h11;
      bus.out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_open = 1'b0; m_carry = 1'b0; m_zac = 1'b0;
      n_checks++;
      if (bus.alu_dataa !== 8'h00 || bus.alu_datab !== 8'h00 || bus.alu_cin !== 1'b0 || bus.alu_add_sub !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_alu: a=%h b=%h cin=%b as=%b, required all 0",
                  bus.alu_dataa, bus.alu_datab, bus.alu_cin, bus.alu_add_sub);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b, required 1", bus.in_ready); end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: cycle %0d got %b, required 0", i, bus.out_valid); end
         @(negedge clock);
      end
      // no chain should be open: continuation word must take in_cin
      run_word(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         run_word(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
                  1'($urandom % 2), 8'($urandom), 8'($urandom), int'($urandom % 3));
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_zero_flag;
      test_back_to_back;
      test_reset_midop;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
